// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: exception codes, CP0 register addresses and the exception-flag
// bundle carried down the pipeline into write-back.
`default_nettype none

package wb_stage_pkg;

   localparam logic [4:0] EX_INT  = 5'h00;
   localparam logic [4:0] EX_ADEL = 5'h04;
   localparam logic [4:0] EX_ADES = 5'h05;
   localparam logic [4:0] EX_SYS  = 5'h08;
   localparam logic [4:0] EX_BP   = 5'h09;
   localparam logic [4:0] EX_RI   = 5'h0a;
   localparam logic [4:0] EX_OV   = 5'h0c;

   // CP0 addresses are {rd, sel}
   localparam logic [7:0] CR_BADVADDR = 8'h40;
   localparam logic [7:0] CR_COUNT    = 8'h48;
   localparam logic [7:0] CR_COMPARE  = 8'h58;
   localparam logic [7:0] CR_STATUS   = 8'h60;
   localparam logic [7:0] CR_CAUSE    = 8'h68;
   localparam logic [7:0] CR_EPC      = 8'h70;

   localparam logic [31:0] EX_ENTRY_BEV1 = 32'hBFC00380;

   typedef struct packed {
      logic adel_if;
      logic ri;
      logic ov;
      logic sys;
      logic bp;
      logic adel_d;
      logic ades;
   } ex_flags_t;

endpackage

`default_nettype wire

// File: rtl/wb_ex_arbiter.sv
// wb_ex_arbiter: combinational priority encoder selecting the precise exception
// (interrupt first) and its code / bad virtual address for the committing instruction.
`default_nettype none

module wb_ex_arbiter
   import wb_stage_pkg::*;
(
   input  logic        has_int,
   input  ex_flags_t   flags,
   input  logic [31:0] pc,
   input  logic [31:0] data_addr,
   output logic        any_ex,
   output logic [4:0]  excode,
   output logic [31:0] badvaddr
);

   always_comb begin
      any_ex   = 1'b1;
      excode   = EX_INT;
      badvaddr = 32'h0;
      if (has_int) begin
         excode = EX_INT;
      end else if (flags.adel_if) begin
         excode   = EX_ADEL;
         badvaddr = pc;
      end else if (flags.ri) begin
         excode = EX_RI;
      end else if (flags.ov) begin
         excode = EX_OV;
      end else if (flags.sys) begin
         excode = EX_SYS;
      end else if (flags.bp) begin
         excode = EX_BP;
      end else if (flags.adel_d) begin
         excode   = EX_ADEL;
         badvaddr = data_addr;
      end else if (flags.ades) begin
         excode   = EX_ADES;
         badvaddr = data_addr;
      end else begin
         any_ex = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// wb_stage: final pipeline register; commits GPR writes, drives CP0 controls and
// raises the pipeline-wide flush for exceptions and ERET.
`default_nettype none

module wb_stage
   import wb_stage_pkg::*;
#(
   parameter logic [31:0] EX_ENTRY = EX_ENTRY_BEV1,
   parameter bit          TRACE_EN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ms_valid,
   output logic        ws_allowin,
   input  logic [31:0] ms_pc,
   input  logic        ms_bd,
   input  logic        ms_gr_we,
   input  logic [4:0]  ms_dest,
   input  logic [31:0] ms_result,
   input  logic        ms_op_mtc0,
   input  logic        ms_op_mfc0,
   input  logic        ms_op_eret,
   input  logic [7:0]  ms_c0_addr,
   input  logic        ms_ex_adel_if,
   input  logic        ms_ex_ri,
   input  logic        ms_ex_ov,
   input  logic        ms_ex_sys,
   input  logic        ms_ex_bp,
   input  logic        ms_ex_adel_d,
   input  logic        ms_ex_ades,
   input  logic [31:0] ms_data_addr,
   input  logic        has_int,
   input  logic [31:0] c0_rdata,
   input  logic [31:0] c0_epc,
   output logic        mtc0_we,
   output logic [7:0]  c0_raddr,
   output logic [31:0] c0_wdata,
   output logic        wb_ex,
   output logic        wb_bd,
   output logic        eret_flush,
   output logic [4:0]  wb_excode,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_badvaddr,
   output logic        ws_flush,
   output logic [31:0] ws_flush_pc,
   output logic [3:0]  rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        ws_fwd_valid,
   output logic [4:0]  ws_fwd_dest,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata
);

   logic        ws_valid;
   logic        ws_ready_go;
   logic [31:0] ws_pc;
   logic        ws_bd;
   logic        ws_gr_we;
   logic [4:0]  ws_dest;
   logic [31:0] ws_result;
   logic        ws_op_mtc0;
   logic        ws_op_mfc0;
   logic        ws_op_eret;
   logic [7:0]  ws_c0_addr;
   logic [31:0] ws_data_addr;
   ex_flags_t   ws_flags;
   ex_flags_t   ms_flags;

   logic        live;
   logic        any_ex;
   logic [4:0]  arb_excode;
   logic [31:0] arb_badvaddr;
   logic        rf_write;

   assign ws_ready_go = 1'b1;
   assign ws_allowin  = !ws_valid || ws_ready_go;

   assign ms_flags = '{adel_if: ms_ex_adel_if, ri: ms_ex_ri, ov: ms_ex_ov, sys: ms_ex_sys,
                       bp: ms_ex_bp, adel_d: ms_ex_adel_d, ades: ms_ex_ades};

   // A flush kills whatever MEM hands over this cycle, since upstream is flushed too.
   always_ff @(posedge clk) begin
      if (reset)
         ws_valid <= 1'b0;
      else if (ws_flush)
         ws_valid <= 1'b0;
      else
         ws_valid <= ms_valid;
   end

   always_ff @(posedge clk) begin
      if (ms_valid && ws_allowin) begin
         ws_pc        <= ms_pc;
         ws_bd        <= ms_bd;
         ws_gr_we     <= ms_gr_we;
         ws_dest      <= ms_dest;
         ws_result    <= ms_result;
         ws_op_mtc0   <= ms_op_mtc0;
         ws_op_mfc0   <= ms_op_mfc0;
         ws_op_eret   <= ms_op_eret;
         ws_c0_addr   <= ms_c0_addr;
         ws_data_addr <= ms_data_addr;
         ws_flags     <= ms_flags;
      end
   end

   wb_ex_arbiter u_arbiter (
      .has_int   (has_int),
      .flags     (ws_flags),
      .pc        (ws_pc),
      .data_addr (ws_data_addr),
      .any_ex    (any_ex),
      .excode    (arb_excode),
      .badvaddr  (arb_badvaddr)
   );

   // Reset in the commit cycle drops any side effect of the instruction in WB.
   assign live = ws_valid && !reset;

   assign wb_ex       = live && any_ex;
   assign wb_excode   = arb_excode;
   assign wb_badvaddr = wb_ex ? arb_badvaddr : 32'h0;
   assign wb_pc       = ws_pc;
   assign wb_bd       = ws_bd;
   assign eret_flush  = live && ws_op_eret && !any_ex;
   assign ws_flush    = wb_ex || eret_flush;
   assign ws_flush_pc = wb_ex ? EX_ENTRY : c0_epc;

   assign mtc0_we  = live && ws_op_mtc0 && !any_ex;
   assign c0_raddr = ws_c0_addr;
   assign c0_wdata = ws_result;

   assign rf_write     = live && ws_gr_we && !any_ex;
   assign rf_we        = {4{rf_write}};
   assign rf_waddr     = ws_dest;
   assign rf_wdata     = ws_op_mfc0 ? c0_rdata : ws_result;
   assign ws_fwd_valid = rf_write;
   assign ws_fwd_dest  = ws_dest;

   if (TRACE_EN) begin : g_trace
      assign debug_wb_pc       = ws_pc;
      assign debug_wb_rf_wen   = rf_we;
      assign debug_wb_rf_wnum  = rf_waddr;
      assign debug_wb_rf_wdata = rf_wdata;
   end else begin : g_no_trace
      assign debug_wb_pc       = 32'h0;
      assign debug_wb_rf_wen   = 4'h0;
      assign debug_wb_rf_wnum  = 5'h0;
      assign debug_wb_rf_wdata = 32'h0;
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed scenarios plus a randomized run checked against a
// behavioural model of the write-back stage.
`default_nettype none

module tb_wb_stage;
   import wb_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_valid, ws_allowin;
   logic [31:0] ms_pc, ms_result, ms_data_addr;
   logic        ms_bd, ms_gr_we, ms_op_mtc0, ms_op_mfc0, ms_op_eret;
   logic [4:0]  ms_dest;
   logic [7:0]  ms_c0_addr;
   logic        ms_ex_adel_if, ms_ex_ri, ms_ex_ov, ms_ex_sys, ms_ex_bp, ms_ex_adel_d, ms_ex_ades;
   logic        has_int;
   logic [31:0] c0_rdata, c0_epc;
   logic        mtc0_we, wb_ex, wb_bd, eret_flush, ws_flush, ws_fwd_valid;
   logic [7:0]  c0_raddr;
   logic [31:0] c0_wdata, wb_pc, wb_badvaddr, ws_flush_pc, rf_wdata;
   logic [4:0]  wb_excode, rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
   logic [3:0]  rf_we, debug_wb_rf_wen;
   logic [31:0] debug_wb_pc, debug_wb_rf_wdata;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   wb_stage #(.EX_ENTRY(32'hBFC00380), .TRACE_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
      .ms_pc(ms_pc), .ms_bd(ms_bd), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
      .ms_result(ms_result), .ms_op_mtc0(ms_op_mtc0), .ms_op_mfc0(ms_op_mfc0),
      .ms_op_eret(ms_op_eret), .ms_c0_addr(ms_c0_addr),
      .ms_ex_adel_if(ms_ex_adel_if), .ms_ex_ri(ms_ex_ri), .ms_ex_ov(ms_ex_ov),
      .ms_ex_sys(ms_ex_sys), .ms_ex_bp(ms_ex_bp), .ms_ex_adel_d(ms_ex_adel_d),
      .ms_ex_ades(ms_ex_ades), .ms_data_addr(ms_data_addr), .has_int(has_int),
      .c0_rdata(c0_rdata), .c0_epc(c0_epc), .mtc0_we(mtc0_we), .c0_raddr(c0_raddr),
      .c0_wdata(c0_wdata), .wb_ex(wb_ex), .wb_bd(wb_bd), .eret_flush(eret_flush),
      .wb_excode(wb_excode), .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
      .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_valid(ws_fwd_valid),
      .ws_fwd_dest(ws_fwd_dest), .debug_wb_pc(debug_wb_pc),
      .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   // Instruction held by the model's write-back slot; fl = {adel_if,ri,ov,sys,bp,adel_d,ades}.
   typedef struct {
      logic        valid, bd, gr_we, mtc0, mfc0, eret;
      logic [4:0]  dest;
      logic [7:0]  c0a;
      logic [31:0] pc, result, daddr;
      logic [6:0]  fl;
   } m_t;

   task automatic clear_ms();
      ms_valid = 0; ms_pc = 0; ms_bd = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0;
      ms_op_mtc0 = 0; ms_op_mfc0 = 0; ms_op_eret = 0; ms_c0_addr = 0; ms_data_addr = 0;
      ms_ex_adel_if = 0; ms_ex_ri = 0; ms_ex_ov = 0; ms_ex_sys = 0; ms_ex_bp = 0;
      ms_ex_adel_d = 0; ms_ex_ades = 0; has_int = 0; c0_rdata = 0; c0_epc = 0;
   endtask

   // Move the driven instruction into WB; MEM then goes idle and flags clear.
   task automatic commit();
      @(posedge clk); #1;
      clear_ms();
      #1;
   endtask

   // Spec priority table: first raised source wins.
   function automatic void ref_ex(input m_t m, input logic hint, output logic ex,
                                  output logic [4:0] code, output logic [31:0] bad);
      logic [7:0]  hit;
      logic [4:0]  codes [8];
      hit   = {m.fl[0], m.fl[1], m.fl[2], m.fl[3], m.fl[4], m.fl[5], m.fl[6], hint};
      codes = '{5'd0, 5'd4, 5'd10, 5'd12, 5'd8, 5'd9, 5'd4, 5'd5};
      ex = 0; code = 0; bad = 0;
      for (int i = 0; i < 8; i++) begin
         if (hit[i] && !ex) begin
            ex   = 1;
            code = codes[i];
            bad  = (i == 1) ? m.pc : (i >= 6) ? m.daddr : 32'h0;
         end
      end
   endfunction

   task automatic test_reset();
      clear_ms();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (rf_we !== 4'h0) $display("FAIL reset_rf_we got %h want 0", rf_we); else passed++;
      total++; if (wb_ex !== 1'b0) $display("FAIL reset_wb_ex got %b want 0", wb_ex); else passed++;
      total++; if (ws_flush !== 1'b0) $display("FAIL reset_flush got %b want 0", ws_flush); else passed++;
      total++; if (ws_fwd_valid !== 1'b0) $display("FAIL reset_fwd got %b want 0", ws_fwd_valid); else passed++;
      total++; if (ws_allowin !== 1'b1) $display("FAIL reset_allowin got %b want 1", ws_allowin); else passed++;
      reset = 0;
   endtask

   task automatic test_alu();
      ms_valid = 1; ms_gr_we = 1; ms_dest = 5; ms_result = 32'h1234; ms_pc = 32'hBFC00010;
      commit();
      total++; if (rf_we !== 4'hF) $display("FAIL alu_rf_we got %h want f", rf_we); else passed++;
      total++; if (rf_waddr !== 5'd5) $display("FAIL alu_waddr got %0d want 5", rf_waddr); else passed++;
      total++; if (rf_wdata !== 32'h1234) $display("FAIL alu_wdata got %h want 1234", rf_wdata); else passed++;
      total++; if (ws_flush !== 1'b0) $display("FAIL alu_flush got %b want 0", ws_flush); else passed++;
      total++; if (ws_fwd_valid !== 1'b1 || ws_fwd_dest !== 5'd5)
         $display("FAIL alu_fwd got %b/%0d want 1/5", ws_fwd_valid, ws_fwd_dest); else passed++;
      total++; if (debug_wb_pc !== 32'hBFC00010) $display("FAIL alu_trace_pc got %h want bfc00010", debug_wb_pc); else passed++;
   endtask

   task automatic test_ov_bd();
      ms_valid = 1; ms_gr_we = 1; ms_dest = 3; ms_ex_ov = 1; ms_bd = 1; ms_pc = 32'hBFC00104;
      @(posedge clk); #1;
      clear_ms();
      // A fresh instruction arrives while WB flushes; it must be killed.
      ms_valid = 1; ms_gr_we = 1; ms_dest = 7; ms_result = 32'h55;
      #1;
      total++; if (wb_ex !== 1'b1 || wb_excode !== EX_OV)
         $display("FAIL ov_ex got %b/%h want 1/0c", wb_ex, wb_excode); else passed++;
      total++; if (wb_bd !== 1'b1 || wb_pc !== 32'hBFC00104)
         $display("FAIL ov_bd_pc got %b/%h want 1/bfc00104", wb_bd, wb_pc); else passed++;
      total++; if (rf_we !== 4'h0) $display("FAIL ov_rf_we got %h want 0", rf_we); else passed++;
      total++; if (ws_flush !== 1'b1 || ws_flush_pc !== 32'hBFC00380)
         $display("FAIL ov_flush got %b/%h want 1/bfc00380", ws_flush, ws_flush_pc); else passed++;
      @(posedge clk); #1;
      clear_ms();
      #1;
      total++; if (rf_we !== 4'h0 || wb_ex !== 1'b0)
         $display("FAIL ov_killed got rf_we=%h wb_ex=%b want 0/0", rf_we, wb_ex); else passed++;
   endtask

   task automatic test_int_ades();
      ms_valid = 1; ms_op_mtc0 = 1; ms_ex_ades = 1; ms_data_addr = 32'h3; ms_pc = 32'hBFC00020;
      @(posedge clk); #1;
      clear_ms();
      has_int = 1;
      #1;
      total++; if (wb_ex !== 1'b1 || wb_excode !== EX_INT)
         $display("FAIL int_code got %b/%h want 1/00", wb_ex, wb_excode); else passed++;
      total++; if (wb_badvaddr !== 32'h0) $display("FAIL int_badvaddr got %h want 0", wb_badvaddr); else passed++;
      total++; if (mtc0_we !== 1'b0) $display("FAIL int_mtc0 got %b want 0", mtc0_we); else passed++;
      has_int = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_adel_if();
      ms_valid = 1; ms_ex_adel_if = 1; ms_ex_ri = 1; ms_pc = 32'hBFC00002;
      commit();
      total++; if (wb_excode !== EX_ADEL) $display("FAIL adelif_code got %h want 04", wb_excode); else passed++;
      total++; if (wb_badvaddr !== 32'hBFC00002)
         $display("FAIL adelif_badvaddr got %h want bfc00002", wb_badvaddr); else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_eret();
      ms_valid = 1; ms_op_eret = 1; ms_pc = 32'hBFC00300;
      @(posedge clk); #1;
      ms_valid = 1; ms_op_eret = 1; ms_pc = 32'hBFC00304;
      c0_epc = 32'hBFC00200;
      #1;
      total++; if (eret_flush !== 1'b1 || wb_ex !== 1'b0)
         $display("FAIL eret_strobe got %b/%b want 1/0", eret_flush, wb_ex); else passed++;
      total++; if (ws_flush !== 1'b1 || ws_flush_pc !== 32'hBFC00200)
         $display("FAIL eret_target got %b/%h want 1/bfc00200", ws_flush, ws_flush_pc); else passed++;
      @(posedge clk); #1;
      clear_ms();
      #1;
      total++; if (eret_flush !== 1'b0) $display("FAIL eret_one_cycle got %b want 0", eret_flush); else passed++;
   endtask

   task automatic test_mfc0_mtc0_reset();
      ms_valid = 1; ms_op_mfc0 = 1; ms_gr_we = 1; ms_dest = 8; ms_c0_addr = CR_STATUS;
      @(posedge clk); #1;
      clear_ms();
      c0_rdata = 32'h0040FF01;
      ms_valid = 1; ms_op_mtc0 = 1; ms_c0_addr = CR_STATUS; ms_result = 32'hCAFE0001;
      #1;
      total++; if (rf_wdata !== 32'h0040FF01) $display("FAIL mfc0_wdata got %h want 0040ff01", rf_wdata); else passed++;
      total++; if (c0_raddr !== CR_STATUS) $display("FAIL mfc0_raddr got %h want 60", c0_raddr); else passed++;
      @(posedge clk); #1;
      ms_result = 32'h0BAD0BAD;
      #1;
      total++; if (mtc0_we !== 1'b1 || c0_wdata !== 32'hCAFE0001)
         $display("FAIL mtc0 got %b/%h want 1/cafe0001", mtc0_we, c0_wdata); else passed++;
      @(posedge clk); #1;
      reset = 1;
      #1;
      total++; if (mtc0_we !== 1'b0) $display("FAIL mtc0_reset got %b want 0", mtc0_we); else passed++;
      @(posedge clk); #1;
      reset = 0;
      clear_ms();
      #1;
      total++; if (mtc0_we !== 1'b0 || rf_we !== 4'h0)
         $display("FAIL post_reset got mtc0=%b rf_we=%h want 0/0", mtc0_we, rf_we); else passed++;
   endtask

   task automatic test_random();
      m_t          m;
      logic        live, ex, e_eret, e_flush;
      logic [4:0]  code;
      logic [31:0] bad;
      int          r;
      m.valid = 0; m.bd = 0; m.gr_we = 0; m.mtc0 = 0; m.mfc0 = 0; m.eret = 0;
      m.dest = 0; m.c0a = 0; m.pc = 0; m.result = 0; m.daddr = 0; m.fl = 0;
      clear_ms();
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         reset    = ($urandom_range(0, 24) == 0);
         has_int  = ($urandom_range(0, 9) == 0);
         c0_rdata = $urandom;
         c0_epc   = $urandom;
         ms_valid = ($urandom_range(0, 3) != 0);
         ms_pc = $urandom; ms_bd = $urandom_range(0, 1); ms_dest = $urandom_range(0, 31);
         ms_result = $urandom; ms_data_addr = $urandom; ms_c0_addr = $urandom_range(0, 255);
         r = $urandom_range(0, 7);
         ms_op_mtc0 = (r == 0); ms_op_mfc0 = (r == 1); ms_op_eret = (r == 2);
         ms_gr_we = (r == 1 || r > 2) ? $urandom_range(0, 3) != 0 : 1'b0;
         ms_ex_adel_if = ($urandom_range(0, 11) == 0); ms_ex_ri = ($urandom_range(0, 11) == 0);
         ms_ex_ov = ($urandom_range(0, 11) == 0); ms_ex_sys = ($urandom_range(0, 11) == 0);
         ms_ex_bp = ($urandom_range(0, 11) == 0); ms_ex_adel_d = ($urandom_range(0, 11) == 0);
         ms_ex_ades = ($urandom_range(0, 11) == 0);
         #1;
         live = m.valid && !reset;
         ref_ex(m, has_int, ex, code, bad);
         ex      = ex && live;
         e_eret  = live && m.eret && !ex;
         e_flush = ex || e_eret;
         total++; if (wb_ex !== ex) $display("FAIL rnd_wb_ex cyc %0d got %b want %b", cyc, wb_ex, ex); else passed++;
         total++; if (wb_badvaddr !== (ex ? bad : 32'h0))
            $display("FAIL rnd_badvaddr cyc %0d got %h want %h", cyc, wb_badvaddr, ex ? bad : 32'h0); else passed++;
         total++; if (eret_flush !== e_eret) $display("FAIL rnd_eret cyc %0d got %b want %b", cyc, eret_flush, e_eret); else passed++;
         total++; if (ws_flush !== e_flush) $display("FAIL rnd_flush cyc %0d got %b want %b", cyc, ws_flush, e_flush); else passed++;
         total++; if (mtc0_we !== (live && m.mtc0 && !ex))
            $display("FAIL rnd_mtc0 cyc %0d got %b want %b", cyc, mtc0_we, live && m.mtc0 && !ex); else passed++;
         total++; if (rf_we !== {4{live && m.gr_we && !ex}} || ws_fwd_valid !== (live && m.gr_we && !ex)
                      || debug_wb_rf_wen !== rf_we)
            $display("FAIL rnd_rf_we cyc %0d got %h/%b want %b", cyc, rf_we, ws_fwd_valid, live && m.gr_we && !ex); else passed++;
         if (ex) begin
            total++; if (wb_excode !== code) $display("FAIL rnd_excode cyc %0d got %h want %h", cyc, wb_excode, code); else passed++;
         end
         if (e_flush) begin
            total++; if (ws_flush_pc !== (ex ? 32'hBFC00380 : c0_epc))
               $display("FAIL rnd_flush_pc cyc %0d got %h want %h", cyc, ws_flush_pc, ex ? 32'hBFC00380 : c0_epc); else passed++;
         end
         if (live) begin
            total++; if (wb_pc !== m.pc || wb_bd !== m.bd || c0_raddr !== m.c0a || c0_wdata !== m.result)
               $display("FAIL rnd_payload cyc %0d got %h/%b/%h/%h want %h/%b/%h/%h", cyc, wb_pc, wb_bd, c0_raddr,
                        c0_wdata, m.pc, m.bd, m.c0a, m.result); else passed++;
            total++; if (rf_waddr !== m.dest || ws_fwd_dest !== m.dest || rf_wdata !== (m.mfc0 ? c0_rdata : m.result))
               $display("FAIL rnd_rf_data cyc %0d got %0d/%h want %0d/%h", cyc, rf_waddr, rf_wdata, m.dest,
                        m.mfc0 ? c0_rdata : m.result); else passed++;
         end
         m.valid = !reset && !e_flush && ms_valid;
         if (ms_valid) begin
            m.pc = ms_pc; m.bd = ms_bd; m.gr_we = ms_gr_we; m.dest = ms_dest; m.result = ms_result;
            m.mtc0 = ms_op_mtc0; m.mfc0 = ms_op_mfc0; m.eret = ms_op_eret; m.c0a = ms_c0_addr;
            m.daddr = ms_data_addr;
            m.fl = {ms_ex_adel_if, ms_ex_ri, ms_ex_ov, ms_ex_sys, ms_ex_bp, ms_ex_adel_d, ms_ex_ades};
         end
         @(posedge clk); #1;
      end
      reset = 0;
      clear_ms();
   endtask

   initial begin
      reset = 1;
      clear_ms();
      test_reset();
      test_alu();
      test_ov_bd();
      test_int_ades();
      test_adel_if();
      test_eret();
      test_mfc0_mtc0_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
